// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared constants and FSM state type for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_reg
// Brief    : Load-enabled {instr, pc, valid} holding register for stalled fetch.
// Revision : 1.0
// ============================================================================
module fetch_skid_reg
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= WIDTH'(C_NOP);
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= i_valid;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Single-issue fetch stage with redirect and a one-entry stall skid.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(C_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_pc,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4,
    output logic             id_valid
);

    localparam logic [WIDTH-1:0] c_align_mask = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] c_reset_pc   = RESET_PC & c_align_mask;
    localparam logic [WIDTH-1:0] c_step       = WIDTH'(4);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic             r_resp_valid;

    logic             w_skid_load;
    logic [WIDTH-1:0] w_skid_instr;
    logic [WIDTH-1:0] w_skid_pc;
    logic             w_skid_valid;
    logic             w_sel_valid;

    assign imem_pc     = r_pc;
    assign w_skid_load = (r_state == RUN) && stall && !redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= c_reset_pc;
            r_resp_pc    <= c_reset_pc;
            r_resp_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (redirect) begin
                r_pc         <= redirect_pc & c_align_mask;
                r_resp_valid <= 1'b0;
            end else if (!stall) begin
                r_pc         <= r_pc + c_step;
                r_resp_pc    <= r_pc;
                r_resp_valid <= 1'b1;
            end
        end
    end

    fetch_skid_reg #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_instr (imem_instr),
        .i_pc    (r_resp_pc),
        .i_valid (r_resp_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc),
        .o_valid (w_skid_valid)
    );

    // In HOLD the memory port has moved on, so decode sees the captured copy
    // until the release cycle has been consumed.
    always_comb begin
        w_state_next = r_state;
        id_instr     = imem_instr;
        id_pc        = r_resp_pc;
        w_sel_valid  = r_resp_valid;
        case (r_state)
            RUN: begin
                if (stall && !redirect) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                id_instr    = w_skid_instr;
                id_pc       = w_skid_pc;
                w_sel_valid = w_skid_valid;
                if (redirect || !stall) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign id_valid    = w_sel_valid && !redirect;
    assign id_pc_plus4 = id_pc + c_step;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with an in-order PC scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        sb_en    = 1'b0;
    logic [31:0] sb_q[$];

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mem[i] = i + 1, word indexed
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    always @(posedge clk) begin
        imem_instr <= reset ? C_NOP : mem_word(imem_pc);
    end

    // Every accepted instruction must be the next one the test expects.
    always @(negedge clk) begin
        if (sb_en && !reset && id_valid && !stall) begin
            logic [31:0] exp_pc;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no instruction", id_pc, id_instr);
            end else begin
                exp_pc = sb_q.pop_front();
                if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc) || id_pc_plus4 !== exp_pc + 32'd4) begin
                    n_errors++;
                    $display("FAIL sb_order: got pc=%h instr=%h pc4=%h, expected pc=%h instr=%h pc4=%h",
                             id_pc, id_instr, id_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb_en = 1'b0;
        sb_q.delete();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        @(negedge clk);
        n_checks++;
        if (imem_pc !== 32'h0 || id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got imem_pc=%h id_valid=%b, expected 00000000 0", imem_pc, id_valid);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_pc !== 32'h0 || id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got imem_pc=%h id_valid=%b, expected 00000000 0", imem_pc, id_valid);
        end
    endtask

    // Continues from the reset-release cycle; leaves id_pc=8 on the outputs.
    task automatic test_free_run();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        sb_en = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'd1) begin
            n_errors++;
            $display("FAIL first_fetch: got valid=%b pc=%h instr=%h, expected 1 00000000 00000001",
                     id_valid, id_pc, id_instr);
        end
        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL free_run_drain: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_stall();
        sb_q.push_back(32'h8);
        sb_q.push_back(32'hC);
        sb_q.push_back(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'd3 || imem_pc !== 32'hC) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h imem_pc=%h, expected 1 00000008 00000003 0000000c",
                         i, id_valid, id_pc, id_instr, imem_pc);
            end
            tick();
        end
        stall = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL stall_drain: got %0d pending, expected 0", sb_q.size());
        end
        sb_en = 1'b0;
    endtask

    task automatic test_redirect(input logic with_stall, input logic from_hold);
        do_reset();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        sb_q.push_back(32'h40);
        sb_q.push_back(32'h44);
        sb_en = 1'b1;
        tick();
        tick();
        tick();
        if (from_hold) begin
            stall = 1'b1;
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        stall = with_stall | from_hold;
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redir_same_cycle(s=%b h=%b): got id_valid=%b, expected 0", with_stall, from_hold, id_valid);
        end
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b0 || imem_pc !== 32'h40) begin
            n_errors++;
            $display("FAIL redir_bubble(s=%b h=%b): got id_valid=%b imem_pc=%h, expected 0 00000040",
                     with_stall, from_hold, id_valid, imem_pc);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'd17) begin
            n_errors++;
            $display("FAIL redir_target(s=%b h=%b): got valid=%b pc=%h instr=%h, expected 1 00000040 00000011",
                     with_stall, from_hold, id_valid, id_pc, id_instr);
        end
        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL redir_drain(s=%b h=%b): got %0d pending, expected 0", with_stall, from_hold, sb_q.size());
        end
        sb_en = 1'b0;
    endtask

    task automatic test_align_wrap();
        logic [31:0] exp_imem[3];
        exp_imem[0] = 32'hFFFF_FFF8;
        exp_imem[1] = 32'hFFFF_FFFC;
        exp_imem[2] = 32'h0000_0000;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        n_checks++;
        if (imem_pc !== 32'h40 || id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL align: got imem_pc=%h id_valid=%b, expected 00000040 0", imem_pc, id_valid);
        end
        tick();
        sb_q.push_back(32'hFFFF_FFF8);
        sb_q.push_back(32'hFFFF_FFFC);
        sb_q.push_back(32'h0);
        sb_en = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_pc !== exp_imem[i]) begin
                n_errors++;
                $display("FAIL wrap_imem[%0d]: got %h, expected %h", i, imem_pc, exp_imem[i]);
            end
            tick();
        end
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL wrap_drain: got %0d pending, expected 0", sb_q.size());
        end
        sb_en = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        sb_en = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL hold_pre_reset: got %0d pending, expected 0", sb_q.size());
        end
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_reset_release: got id_valid=%b, expected 0", id_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'd1) begin
            n_errors++;
            $display("FAIL hold_reset_first: got valid=%b pc=%h instr=%h, expected 1 00000000 00000001",
                     id_valid, id_pc, id_instr);
        end
        tick();
        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL hold_reset_drain: got %0d pending, expected 0", sb_q.size());
        end
        sb_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            sb_q.push_back(32'(i * 4));
        end
        sb_en = 1'b1;
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) begin
            stall = ($urandom_range(0, 2) == 0);
            tick();
        end
        sb_en = 1'b0;
        stall = 1'b0;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_stall_timeout: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect(1'b0, 1'b0);
        test_redirect(1'b1, 1'b0);
        test_redirect(1'b1, 1'b1);
        test_align_wrap();
        test_reset_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter WIDTH, default 32, sets instruction and address width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 stall  input  1  hazard unit: decode cannot accept this cycle; hold fetch and outputs.
REQ-006 redirect  input  1  taken branch/jump; load a new PC and squash the in-flight fetch.
REQ-007 redirect_pc  input  WIDTH  target address, valid when redirect=1.
REQ-008 imem_pc  output  WIDTH  fetch address to the instruction memory read port.
REQ-009 imem_instr  input  WIDTH  instruction memory read data (registered, 1-cycle latency; NOP while memory is in reset).
REQ-010 id_instr  output  WIDTH  instruction presented to decode.
REQ-011 id_pc  output  WIDTH  address of id_instr.
REQ-012 id_pc_plus4  output  WIDTH  id_pc + 4, modulo 2^WIDTH.
REQ-013 id_valid  output  1  id_instr/id_pc are a real, non-squashed instruction.

Function
REQ-014 pc_reg shall drive imem_pc combinationally; bits [1:0] are always 2'b00.
REQ-015 Advance: when stall=0 and redirect=0, pc_reg <= pc_reg+4 (wraps 32'hFFFF_FFFC -> 0), resp_pc <= pc_reg, resp_valid <= 1.
REQ-016 Redirect: when redirect=1, pc_reg <= {redirect_pc[WIDTH-1:2],2'b00}, resp_valid <= 0, state <= RUN, regardless of stall (redirect wins).
REQ-017 Redirect cycle: id_valid shall be 0 combinationally in the same cycle redirect=1.
REQ-018 FSM states RUN and HOLD only.
REQ-019 RUN: id_instr=imem_instr, id_pc=resp_pc, id_valid=resp_valid.
REQ-020 RUN & stall=1 & redirect=0: pc_reg holds; skid_instr<=imem_instr, skid_pc<=resp_pc, skid_valid<=resp_valid; next state HOLD.
REQ-021 HOLD: id_instr=skid_instr, id_pc=skid_pc, id_valid=skid_valid; skid and pc_reg hold while stall=1.
REQ-022 HOLD & stall=0 & redirect=0: outputs still come from skid this cycle; advance per REQ-015; next state RUN.
REQ-023 Each instruction shall appear on id_* with id_valid=1 exactly once per non-stalled cycle, in program order, with no duplicates or drops across a stall of any length (1..N).
REQ-024 Latency: the instruction at address A appears on id_* the cycle after imem_pc=A is accepted (1 cycle).

Reset
REQ-025 reset=1: pc_reg<=RESET_PC, resp_pc<=RESET_PC, resp_valid<=0, skid_valid<=0, state<=RUN; reset has priority over redirect and stall.
REQ-026 Reset-release cycle: imem_pc=RESET_PC, id_valid=0. The next cycle presents mem[RESET_PC] with id_valid=1.
REQ-027 Reset mid-HOLD discards skid contents; no stale instruction is presented afterwards.

Structure
REQ-028 The shared package holds the NOP encoding, the RESET_PC default, and an enum type for the fetch FSM state (RUN/HOLD).
REQ-029 One sub-module, fetch_skid_reg, holds the {instr, pc, valid} skid buffer with a load enable. All other logic is flat.

Verification
REQ-030 Reset, then free run 4 cycles with mem[i]=i+1: id_pc sequence 0,4,8 with id_instr 1,2,3, id_valid=1 from the 2nd post-reset cycle.
REQ-031 Stall for 3 cycles while id_pc=8: id_pc=8/id_instr=3 held for all 3 cycles. After release, the next instructions are 12 then 16, with no duplicate or skip.
REQ-032 Redirect to 0x40 while id_pc=8: id_valid=0 that cycle and the next, then id_pc=0x40 with id_instr=mem[16].
REQ-033 Redirect with stall=1 asserted in the same cycle (including from HOLD): same result as REQ-032, and the skid is discarded.
REQ-034 Redirect_pc=0x43: imem_pc=0x40. Start at pc 0xFFFF_FFF8 and free run: imem_pc goes 0xFFFF_FFFC then 0x0.
REQ-035 Reset asserted in HOLD: the next id_valid=1 instruction is mem[RESET_PC].
